// File: rtl/time_set_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : time_set_router_pkg
// Purpose  : Shared field indices, router mode encoding and the select-width
//            helper used by the router, its interface and the display mux.
// Revision : 1.0  initial release
// ============================================================================
package time_set_router_pkg;

    localparam int FLD_HOUR = 0;
    localparam int FLD_MIN  = 1;
    localparam int FLD_SEC  = 2;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    // sel carries 0..num_fields-1 for a field, num_fields for RUN
    function automatic int sel_width(input int num_fields);
        return $clog2(num_fields + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_router_if.sv
`default_nettype none
// ============================================================================
// Module   : time_set_router_if
// Purpose  : Key/carry inputs and strobe/select/blink outputs of the router.
// Revision : 1.0  initial release
// ============================================================================
interface time_set_router_if
    import time_set_router_pkg::*;
#(
    parameter int NUM_FIELDS = 3
);
    localparam int SEL_W = sel_width(NUM_FIELDS);

    logic                  turn;
    logic                  change;
    logic [NUM_FIELDS-1:0] carry_in;
    logic [NUM_FIELDS-1:0] inc_out;
    logic [SEL_W-1:0]      sel;
    logic                  setting;
    logic [NUM_FIELDS-1:0] blink_on;

    modport master (
        output turn, change, carry_in,
        input  inc_out, sel, setting, blink_on
    );

    modport slave (
        input  turn, change, carry_in,
        output inc_out, sel, setting, blink_on
    );

endinterface
`default_nettype wire

// File: rtl/time_set_router_key_edge.sv
`default_nettype none
// ============================================================================
// Module   : key_edge
// Purpose  : One-cycle rising-edge pulse from a debounced key level.
// Revision : 1.0  initial release
// ============================================================================
module key_edge (
    input  wire logic clk,
    input  wire logic i_key,
    output logic      o_rise
);
    // Reset also loads the live key level, which is exactly the normal update,
    // so no reset input is needed: a key held through reset yields no edge.
    logic r_key_q;

    always_ff @(posedge clk) begin
        r_key_q <= i_key;
    end

    assign o_rise = i_key & ~r_key_q;

endmodule
`default_nettype wire

// File: rtl/time_set_router.sv
`default_nettype none
// ============================================================================
// Module   : time_set_router
// Purpose  : Steers the change key to the selected time field in set mode,
//            forwards counter-chain carries in run mode, adds hold-to-repeat
//            and a blink strobe for the field being set.
// Revision : 1.0  initial release
// ============================================================================
module time_set_router
    import time_set_router_pkg::*;
#(
    parameter int NUM_FIELDS = 3,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 5_000_000,
    parameter int BLINK_HALF = 12_500_000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    time_set_router_if.slave  bus
);
    localparam int SEL_W = sel_width(NUM_FIELDS);
    localparam int RC_W  = $clog2(REPEAT_DLY + REPEAT_PER + 1);
    localparam int BC_W  = $clog2(BLINK_HALF + 1);

    localparam logic [SEL_W-1:0]      c_sel_run    = SEL_W'(NUM_FIELDS);
    localparam logic [SEL_W-1:0]      c_sel_last   = SEL_W'(NUM_FIELDS - 1);
    localparam logic [RC_W-1:0]       c_rep_dly    = RC_W'(REPEAT_DLY);
    localparam logic [RC_W-1:0]       c_rep_wrap   = RC_W'(REPEAT_DLY + REPEAT_PER);
    localparam logic [RC_W-1:0]       c_rep_first  = RC_W'(1);
    localparam logic [BC_W-1:0]       c_blink_last = BC_W'(BLINK_HALF - 1);
    localparam logic [NUM_FIELDS-1:0] c_all_on     = '1;
    localparam logic [NUM_FIELDS-1:0] c_one        = NUM_FIELDS'(1);

    logic w_turn_rise;
    logic w_change_rise;

    key_edge u_turn_edge (
        .clk    (clk),
        .i_key  (bus.turn),
        .o_rise (w_turn_rise)
    );

    key_edge u_change_edge (
        .clk    (clk),
        .i_key  (bus.change),
        .o_rise (w_change_rise)
    );

    mode_e                 r_mode;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_setting;
    logic [NUM_FIELDS-1:0] r_inc;
    logic [NUM_FIELDS-1:0] r_blink_on;
    logic [RC_W-1:0]       r_rep_cnt;
    logic [BC_W-1:0]       r_blink_cnt;
    logic                  r_phase;

    mode_e                 w_mode_nxt;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic [NUM_FIELDS-1:0] w_inc_nxt;
    logic [NUM_FIELDS-1:0] w_blink_on_nxt;
    logic [RC_W-1:0]       w_rep_nxt;
    logic [RC_W-1:0]       w_rep_inc;
    logic [BC_W-1:0]       w_blink_cnt_nxt;
    logic                  w_phase_nxt;
    logic                  w_pulse;

    always_comb begin
        w_mode_nxt      = r_mode;
        w_sel_nxt       = r_sel;
        w_inc_nxt       = '0;
        w_blink_on_nxt  = c_all_on;
        w_rep_nxt       = '0;
        w_rep_inc       = r_rep_cnt + 1'b1;
        w_blink_cnt_nxt = '0;
        w_phase_nxt     = 1'b1;
        w_pulse         = 1'b0;

        if (w_turn_rise) begin
            // turn has priority over any change edge or repeat in the same cycle
            if (r_mode == MODE_RUN) begin
                w_mode_nxt = MODE_SET;
                w_sel_nxt  = '0;
            end else if (r_sel == c_sel_last) begin
                w_mode_nxt = MODE_RUN;
                w_sel_nxt  = c_sel_run;
            end else begin
                w_sel_nxt  = r_sel + 1'b1;
            end
        end else if (r_mode == MODE_RUN) begin
            w_inc_nxt = bus.carry_in;
        end else begin
            if (w_change_rise) begin
                w_rep_nxt = c_rep_first;
                w_pulse   = 1'b1;
            end else if (bus.change && (r_rep_cnt != '0)) begin
                // after the initial delay the counter loops DLY..DLY+PER-1, never wraps
                if (w_rep_inc == c_rep_wrap) begin
                    w_rep_nxt = c_rep_dly;
                    w_pulse   = 1'b1;
                end else begin
                    w_rep_nxt = w_rep_inc;
                    w_pulse   = (w_rep_inc == c_rep_dly);
                end
            end

            if (w_pulse) begin
                w_inc_nxt = c_one << r_sel;
            end else if (r_blink_cnt == c_blink_last) begin
                w_phase_nxt = ~r_phase;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                w_phase_nxt     = r_phase;
            end

            w_blink_on_nxt = w_phase_nxt ? c_all_on : ~(c_one << r_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= MODE_RUN;
            r_sel       <= c_sel_run;
            r_setting   <= 1'b0;
            r_inc       <= '0;
            r_blink_on  <= c_all_on;
            r_rep_cnt   <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else begin
            r_mode      <= w_mode_nxt;
            r_sel       <= w_sel_nxt;
            r_setting   <= (w_mode_nxt == MODE_SET);
            r_inc       <= w_inc_nxt;
            r_blink_on  <= w_blink_on_nxt;
            r_rep_cnt   <= w_rep_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    assign bus.inc_out  = r_inc;
    assign bus.sel      = r_sel;
    assign bus.setting  = r_setting;
    assign bus.blink_on = r_blink_on;

endmodule
`default_nettype wire

// File: tb/tb_time_set_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_router
// Purpose  : Scoreboard bench for time_set_router against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_time_set_router;
    localparam int N   = 3;
    localparam int DLY = 8;
    localparam int PER = 3;
    localparam int BH  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    time_set_router_if #(.NUM_FIELDS(N)) bus ();

    time_set_router #(
        .NUM_FIELDS (N),
        .REPEAT_DLY (DLY),
        .REPEAT_PER (PER),
        .BLINK_HALF (BH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        int         sel;
        logic       setting;
        logic [2:0] inc;
        logic [2:0] blink;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total      = 0;
    int   bad        = 0;
    int   cyc        = 0;
    int   dut_pulses = 0;

    // model state: m_hold = cycles change held since its rise in set mode,
    // m_t = cycles since the edited field was last forced visible
    int   m_sel = N;
    int   m_hold = 0;
    int   m_t = 0;
    logic m_prev_turn = 1'b0;
    logic m_prev_change = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.inc_out != 3'b000) dut_pulses++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            check("sel",      int'(bus.sel),      e.sel);
            check("setting",  int'(bus.setting),  int'(e.setting));
            check("inc_out",  int'(bus.inc_out),  int'(e.inc));
            check("blink_on", int'(bus.blink_on), int'(e.blink));
        end
    end

    task automatic step(input logic t, input logic c, input logic [2:0] carry, input logic r);
        exp_t x;
        logic tr, cr, pulse;
        @(negedge clk);
        #1;
        bus.turn     = t;
        bus.change   = c;
        bus.carry_in = carry;
        reset        = r;
        x.inc        = 3'b000;
        if (r) begin
            m_sel  = N;
            m_hold = 0;
            m_t    = 0;
        end else begin
            tr = t && !m_prev_turn;
            cr = c && !m_prev_change;
            if (tr) begin
                m_sel  = (m_sel + 1) % (N + 1);
                m_hold = 0;
                m_t    = 0;
            end else if (m_sel == N) begin
                x.inc  = carry;
                m_hold = 0;
                m_t    = 0;
            end else begin
                if (cr)                   m_hold = 1;
                else if (c && m_hold > 0) m_hold = m_hold + 1;
                else                      m_hold = 0;
                pulse = (m_hold == 1) || (m_hold >= DLY && ((m_hold - DLY) % PER) == 0);
                if (pulse) begin
                    x.inc = 3'(1 << m_sel);
                    m_t   = 0;
                end else begin
                    m_t = m_t + 1;
                end
            end
        end
        m_prev_turn   = t;
        m_prev_change = c;
        x.cyc     = cyc + 1;
        x.sel     = m_sel;
        x.setting = (m_sel != N);
        x.blink   = 3'b111;
        if (m_sel != N) x.blink[m_sel] = (((m_t / BH) % 2) == 0);
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic turn_rise();
        step(1'b1, 1'b0, 3'b000, 1'b0);
        step(1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        int   p0;
        logic rc;
        bus.turn     = 1'b0;
        bus.change   = 1'b0;
        bus.carry_in = 3'b000;

        // reset with turn held, then a single carry forwarded in RUN
        repeat (3) step(1'b1, 1'b0, 3'b000, 1'b1);
        repeat (2) step(1'b1, 1'b0, 3'b000, 1'b0);
        step(1'b0, 1'b0, 3'b000, 1'b0);
        step(1'b0, 1'b0, 3'b001, 1'b0);
        idle(2);

        // cycle through all fields, carries frozen while setting
        turn_rise();
        turn_rise();
        repeat (3) step(1'b0, 1'b0, 3'b111, 1'b0);
        turn_rise();
        turn_rise();
        turn_rise();
        turn_rise();

        // sel=1: short press then a 20-cycle hold
        p0 = dut_pulses;
        repeat (2) step(1'b0, 1'b1, 3'b000, 1'b0);
        idle(3);
        check("short_press_pulses", dut_pulses - p0, 1);
        p0 = dut_pulses;
        repeat (20) step(1'b0, 1'b1, 3'b000, 1'b0);
        idle(4);
        check("hold_pulses", dut_pulses - p0, 6);

        // to sel=0, watch blink, change restarts it, then back to RUN
        turn_rise();
        turn_rise();
        turn_rise();
        idle(12);
        step(1'b0, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b0, 3'b000, 1'b0);
        idle(6);
        turn_rise();
        turn_rise();
        turn_rise();
        idle(2);

        // simultaneous turn/change at sel=2, then reset mid-repeat
        turn_rise();
        turn_rise();
        turn_rise();
        step(1'b1, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b0, 3'b000, 1'b0);
        turn_rise();
        repeat (12) step(1'b0, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b1, 3'b000, 1'b1);
        repeat (3) step(1'b0, 1'b1, 3'b010, 1'b0);
        step(1'b0, 1'b0, 3'b000, 1'b0);

        // randomized traffic
        rc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic rt;
            logic rr;
            rt = ($urandom_range(0, 24) == 0);
            rr = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 9) == 0) rc = ~rc;
            step(rt, rc, 3'($urandom_range(0, 7)), rr);
        end

        idle(1);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
